// File: rtl/ahb_lite_dma_master.sv
// Single-outstanding AHB-Lite master: takes one command at a time, runs one
// NONSEQ transfer with wait/error/timeout handling, returns one response.
module ahb_lite_dma_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        core_clk,
  input  logic        reset_l,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        bus_hung,
  output logic [31:0] haddr,
  output logic [2:0]  hburst,
  output logic        hmastlock,
  output logic [3:0]  hprot,
  output logic [2:0]  hsize,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [63:0] hwdata,
  output logic        hsel,
  input  logic [63:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_RESP = 3'd3,
    ST_HUNG = 3'd4
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [2:0]  hsize_q, hsize_d;
  logic        hwrite_q, hwrite_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] hwdata_q, hwdata_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hsel_q, hsel_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic        bus_hung_q, bus_hung_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0] tmo_inc_s;

  function automatic logic cmd_legal(input logic [2:0] size, input logic [31:0] addr);
    logic ok;
    case (size)
      3'd0:    ok = 1'b1;
      3'd1:    ok = (addr[0] == 1'b0);
      3'd2:    ok = (addr[1:0] == 2'b00);
      3'd3:    ok = (addr[2:0] == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign tmo_inc_s = tmo_cnt_q + 16'd1;

  // Next-state and next-output logic; bus outputs default to idle each cycle
  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    hsize_d     = hsize_q;
    hwrite_d    = hwrite_q;
    wdata_d     = wdata_q;
    hwdata_d    = 64'd0;
    htrans_d    = 2'b00;
    hsel_d      = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    bus_hung_d  = bus_hung_q;
    tmo_cnt_d   = tmo_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_legal(cmd_size, cmd_addr)) begin
            state_d  = ST_ADDR;
            haddr_d  = cmd_addr;
            hsize_d  = cmd_size;
            hwrite_d = cmd_write;
            wdata_d  = cmd_wdata;
            htrans_d = 2'b10;
            hsel_d   = 1'b1;
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 64'd0;
            rsp_err_d   = 2'b11;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (hready) begin
          state_d   = ST_DATA;
          tmo_cnt_d = 16'd0;
          hwdata_d  = hwrite_q ? wdata_q : 64'd0;
        end else begin
          htrans_d = 2'b10;
          hsel_d   = 1'b1;
        end
      end
      ST_DATA: begin
        if (hready) begin
          // First beat of a two-cycle error response is just another wait
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = hresp ? 2'b01 : 2'b00;
          rsp_rdata_d = (!hwrite_q && !hresp) ? hrdata : 64'd0;
        end else begin
          tmo_cnt_d = tmo_inc_s;
          if (tmo_inc_s == TMO_LIMIT) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 2'b10;
            rsp_rdata_d = 64'd0;
            bus_hung_d  = 1'b1;
          end else begin
            hwdata_d = hwrite_q ? wdata_q : 64'd0;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = bus_hung_q ? ST_HUNG : ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 64'd0;
          rsp_err_d   = 2'b00;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_HUNG: begin
        state_d = ST_HUNG;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge core_clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= ST_IDLE;
      haddr_q     <= 32'd0;
      hsize_q     <= 3'd0;
      hwrite_q    <= 1'b0;
      wdata_q     <= 64'd0;
      hwdata_q    <= 64'd0;
      htrans_q    <= 2'b00;
      hsel_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 2'b00;
      bus_hung_q  <= 1'b0;
      tmo_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      wdata_q     <= wdata_d;
      hwdata_q    <= hwdata_d;
      htrans_q    <= htrans_d;
      hsel_q      <= hsel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      bus_hung_q  <= bus_hung_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign bus_hung  = bus_hung_q;
  assign haddr     = haddr_q;
  assign hsize     = hsize_q;
  assign hwrite    = hwrite_q;
  assign hwdata    = hwdata_q;
  assign htrans    = htrans_q;
  assign hsel      = hsel_q;
  assign hburst    = 3'b000;
  assign hmastlock = 1'b0;
  assign hprot     = 4'b0011;

endmodule

// File: doc/ahb_lite_dma_master.md
AHB_LITE_DMA_MASTER -- requirements
Module: ahb_lite_dma_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: data-phase cycles without HREADY before timeout is declared; legal range 2..65535.
REQ-002 SHALL have port core_clk  in  1  clock; all flops rising-edge.
REQ-003 SHALL have port reset_l  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  in  1  requester has a command.
REQ-005 SHALL have port cmd_ready  out  1  block accepts a command this cycle.
REQ-006 SHALL have port cmd_write  in  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  in  32  byte address.
REQ-008 SHALL have port cmd_size  in  3  HSIZE encoding; 0..3 legal.
REQ-009 SHALL have port cmd_wdata  in  64  write data, already byte-lane placed.
REQ-010 SHALL have port rsp_valid  out  1  response available.
REQ-011 SHALL have port rsp_ready  in  1  requester takes the response.
REQ-012 SHALL have port rsp_rdata  out  64  read data, unshifted; 0 for writes and errors.
REQ-013 SHALL have port rsp_err  out  2  00 ok, 01 HRESP error, 10 timeout, 11 illegal command.
REQ-014 SHALL have port bus_hung  out  1  sticky flag, set on timeout.
REQ-015 SHALL have AHB master ports haddr(32), hburst(3), hmastlock(1), hprot(4), hsize(3), htrans(2), hwrite(1), hwdata(64), hsel(1) out; hrdata(64), hready(1), hresp(1) in.

Function
REQ-016 SHALL implement the FSM states IDLE, ADDR, DATA, RESP, HUNG.
REQ-017 SHALL drive cmd_ready = (state==IDLE); cmd_ready SHALL be 0 in all other states, including HUNG.
REQ-018 SHALL, in IDLE on cmd_valid&cmd_ready, register cmd_write/addr/size/wdata and go to ADDR.
REQ-019 SHALL treat a command as illegal when cmd_size>3 or cmd_addr is misaligned to 2^cmd_size; such a command SHALL go directly IDLE->RESP with rsp_err=11 and SHALL issue no bus transfer.
REQ-020 SHALL, in ADDR, drive htrans=2'b10 (NONSEQ), hsel=1, haddr/hsize/hwrite from the registered command, hburst=000, hmastlock=0, hprot=4'b0011.
REQ-021 SHALL hold all address-phase signals stable in ADDR until hready=1 is sampled, then go to DATA.
REQ-022 SHALL drive htrans=00 and hsel=0 in every state other than ADDR; haddr/hsize/hwrite SHALL hold their last value.
REQ-023 SHALL drive hwdata with the registered wdata during DATA for writes, and 0 at all other times.
REQ-024 SHALL, in DATA, complete on the first cycle with hready=1: capture hrdata for reads, set rsp_err=01 if hresp=1, else 00, and go to RESP.
REQ-025 SHALL accept the two-cycle AHB error response (hresp=1/hready=0 then hresp=1/hready=1) and report it as one completion with rsp_err=01.
REQ-026 SHALL count DATA cycles with hready=0 in a 16-bit counter cleared on DATA entry; when the count reaches TIMEOUT_CYCLES, it SHALL report rsp_err=10, set bus_hung, and go to RESP.
REQ-027 SHALL hold rsp_valid=1 in RESP with stable rsp_rdata/rsp_err until rsp_ready=1.
REQ-028 SHALL, on leaving RESP, go to HUNG if bus_hung=1, else to IDLE; HUNG SHALL be left only by reset.
REQ-029 SHALL give a zero-wait-state slave this latency: command accepted at edge E0, NONSEQ visible after E0, DATA after E1, rsp_valid visible after E2.
REQ-030 SHALL allow a new command no earlier than the cycle after a response handshake; there is one outstanding transfer maximum.
REQ-031 SHALL ignore rsp_ready outside RESP and cmd_valid outside IDLE.

Reset
REQ-032 SHALL, while reset_l=0, force state=IDLE, htrans=00, hsel=0, haddr=0, hsize=0, hwrite=0, hburst=000, hmastlock=0, hprot=4'b0011, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=00, bus_hung=0, timeout counter=0.
REQ-033 SHALL, on reset assertion mid-transfer in any state, abandon the transfer immediately and emit no response after reset release.
REQ-034 SHALL present cmd_ready=1 in the first cycle after reset release.

Verification
REQ-035 SHALL verify a zero-wait read: addr 0x0000_1000, size 3, slave returns 0x0123_4567_89AB_CDEF; expect one NONSEQ, then rsp_valid two edges later with that data and rsp_err=00.
REQ-036 SHALL verify a 3-wait write: addr 0x0000_2004, size 2, wdata 0xDEAD_BEEF_0000_0000; expect hwdata held for 4 DATA cycles, then rsp_err=00 and rsp_rdata=0.
REQ-037 SHALL verify an error response: slave gives the two-cycle hresp response; expect rsp_err=01, exactly one response, and cmd_ready=1 after the handshake.
REQ-038 SHALL verify an illegal command: addr 0x0000_0003, size 1; expect no NONSEQ on the bus and rsp_err=11 on the cycle after acceptance.
REQ-039 SHALL verify timeout: TIMEOUT_CYCLES=4 with hready held at 0; expect rsp_err=10 after 4 DATA cycles, bus_hung=1, and cmd_ready=0 after the handshake until reset.
REQ-040 SHALL verify reset mid-DATA with rsp_ready held at 1: expect all REQ-032 values, no rsp_valid pulse, and cmd_ready=1 after release.
